ts_sync_aligner: RTL and testbench

- Sits directly upstream of the TS monitor/replacer complex. It feeds that complex's mpeg_data/mpeg_valid/mpeg_sync inputs.
- Takes a raw, possibly misaligned byte stream from the front-end.
- Acquires and tracks 188-byte TS packet alignment on the 0x47 sync byte, with lock/unlock hysteresis.
- Emits only whole aligned packets, with a one-cycle sync strobe on each packet's first byte.
- Exposes lock status and packet/loss counters for register readback.

---
 rtl/ts_pkg.sv | 17 +
 rtl/ts_sync_aligner.sv | 182 ++++++++++++++++++
 tb/tb_ts_sync_aligner.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// ts_pkg: constants and types shared between the sync aligner and the
// downstream TS monitor/replacer complex.
//   TS_PACK_BYTE_SIZE - bytes per transport stream packet
//   TS_SYNC_BYTE      - value of the first byte of every packet
//   ts_align_state_t  - alignment state of the sync aligner
package ts_pkg;

  localparam int          TS_PACK_BYTE_SIZE = 188;
  localparam logic [7:0]  TS_SYNC_BYTE      = 8'h47;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_align_state_t;

endpackage

// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner: acquires and tracks 188-byte TS packet alignment on a raw
// byte stream and forwards only whole, aligned packets.
//
// Ports:
//   clk          - byte clock
//   rst_n        - synchronous active-low reset
//   in_data      - raw stream byte
//   in_valid     - in_data is valid this cycle
//   out_data     - aligned byte (holds its last value when nothing is emitted)
//   out_valid    - out_data is valid
//   out_sync     - first byte of a packet (only together with out_valid)
//   locked       - aligner is in the LOCKED state
//   packet_count - packets emitted since reset (wraps)
//   lost_count   - LOCKED->HUNT transitions since reset (wraps)
module ts_sync_aligner
  import ts_pkg::*;
#(
  parameter int         PACK_BYTE_SIZE = TS_PACK_BYTE_SIZE,
  parameter logic [7:0] SYNC_BYTE      = TS_SYNC_BYTE,
  parameter int         LOCK_COUNT     = 3,
  parameter int         UNLOCK_COUNT   = 3,
  parameter int         CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sync,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] packet_count,
  output logic [CNT_WIDTH-1:0] lost_count
);

  localparam int IDX_W = $clog2(PACK_BYTE_SIZE);

  ts_align_state_t state_reg, state_next;
  logic [IDX_W-1:0] byte_idx_reg, byte_idx_next;
  logic [3:0]       good_cnt_reg, good_cnt_next;
  logic [3:0]       bad_cnt_reg, bad_cnt_next;

  logic [7:0]           out_data_reg;
  logic                 out_valid_reg;
  logic                 out_sync_reg;
  logic                 locked_reg;
  logic [CNT_WIDTH-1:0] packet_count_reg;
  logic [CNT_WIDTH-1:0] lost_count_reg;

  logic             is_sync;
  logic             at_boundary;
  logic [IDX_W-1:0] idx_inc;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;
  logic             emit;
  logic             emit_sync;
  logic             lose;

  assign is_sync     = (in_data == SYNC_BYTE);
  assign at_boundary = (byte_idx_reg == '0);
  assign idx_inc     = (byte_idx_reg == IDX_W'(PACK_BYTE_SIZE - 1)) ? '0
                                                                   : byte_idx_reg + 1'b1;
  assign good_inc    = good_cnt_reg + 4'd1;
  assign bad_inc     = bad_cnt_reg + 4'd1;

  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    emit          = 1'b0;
    emit_sync     = 1'b0;
    lose          = 1'b0;

    // Nothing moves on idle cycles; the byte index counts valid bytes only.
    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          if (is_sync) begin
            state_next    = VERIFY;
            good_cnt_next = 4'd1;
            byte_idx_next = IDX_W'(1);
          end
        end

        VERIFY: begin
          byte_idx_next = idx_inc;
          if (at_boundary) begin
            if (is_sync) begin
              good_cnt_next = good_inc;
              if (good_inc == 4'(LOCK_COUNT)) begin
                // The sync byte that completes the lock is itself the
                // first emitted byte.
                state_next   = LOCKED;
                bad_cnt_next = 4'd0;
                emit         = 1'b1;
                emit_sync    = 1'b1;
              end
            end else begin
              // The failing byte is known not to be a sync byte, so hunting
              // resumes with the next byte rather than rescanning this one.
              state_next    = HUNT;
              good_cnt_next = 4'd0;
              byte_idx_next = '0;
            end
          end
        end

        LOCKED: begin
          byte_idx_next = idx_inc;
          emit          = 1'b1;
          if (at_boundary) begin
            emit_sync = 1'b1;
            if (is_sync) begin
              bad_cnt_next = 4'd0;
            end else if (bad_inc < 4'(UNLOCK_COUNT)) begin
              // Flywheel: keep the packet framing across a damaged sync byte.
              bad_cnt_next = bad_inc;
            end else begin
              // Loss only happens on a boundary, so no partial packet leaks.
              state_next    = HUNT;
              lose          = 1'b1;
              emit          = 1'b0;
              emit_sync     = 1'b0;
              bad_cnt_next  = 4'd0;
              good_cnt_next = 4'd0;
              byte_idx_next = '0;
            end
          end
        end

        default: begin
          state_next    = HUNT;
          byte_idx_next = '0;
          good_cnt_next = 4'd0;
          bad_cnt_next  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= HUNT;
      byte_idx_reg     <= '0;
      good_cnt_reg     <= 4'd0;
      bad_cnt_reg      <= 4'd0;
      out_data_reg     <= 8'd0;
      out_valid_reg    <= 1'b0;
      out_sync_reg     <= 1'b0;
      locked_reg       <= 1'b0;
      packet_count_reg <= '0;
      lost_count_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      byte_idx_reg  <= byte_idx_next;
      good_cnt_reg  <= good_cnt_next;
      bad_cnt_reg   <= bad_cnt_next;
      out_valid_reg <= emit;
      out_sync_reg  <= emit_sync;
      locked_reg    <= (state_next == LOCKED);
      if (emit) begin
        out_data_reg <= in_data;
      end
      // Counts packets as they are presented downstream.
      if (out_valid_reg && out_sync_reg) begin
        packet_count_reg <= packet_count_reg + CNT_WIDTH'(1);
      end
      if (lose) begin
        lost_count_reg <= lost_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign out_data     = out_data_reg;
  assign out_valid    = out_valid_reg;
  assign out_sync     = out_sync_reg;
  assign locked       = locked_reg;
  assign packet_count = packet_count_reg;
  assign lost_count   = lost_count_reg;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Testbench for ts_sync_aligner. Two instances share the input stream:
// inst0 uses LOCK_COUNT=3/UNLOCK_COUNT=3, inst1 uses LOCK_COUNT=2/UNLOCK_COUNT=1.
// A whole-stream reference model decides, per input byte, whether it is
// emitted; expectations are queued at issue time and a negedge monitor
// checks whatever the DUTs present.
module tb_ts_sync_aligner;

  localparam int         PKT  = 188;
  localparam logic [7:0] SYNC = 8'h47;
  localparam int         MAXN = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;

  logic [7:0]  o_data  [2];
  logic        o_valid [2];
  logic        o_sync  [2];
  logic        o_lock  [2];
  logic [31:0] o_pkt   [2];
  logic [31:0] o_lost  [2];

  always #5 clk = ~clk;

  ts_sync_aligner #(.LOCK_COUNT(3), .UNLOCK_COUNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(o_data[0]), .out_valid(o_valid[0]), .out_sync(o_sync[0]),
    .locked(o_lock[0]), .packet_count(o_pkt[0]), .lost_count(o_lost[0])
  );

  ts_sync_aligner #(.LOCK_COUNT(2), .UNLOCK_COUNT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(o_data[1]), .out_valid(o_valid[1]), .out_sync(o_sync[1]),
    .locked(o_lock[1]), .packet_count(o_pkt[1]), .lost_count(o_lost[1])
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       sync;
  } exp_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] stream [$];
  logic exp_emit [2][MAXN];
  logic exp_sync [2][MAXN];
  logic exp_lock [2][MAXN];
  int   exp_lost [2][MAXN];
  int   exp_pkt  [2][MAXN];
  int   tot_pkt  [2];
  int   tot_lost [2];

  exp_t sb0 [$];
  exp_t sb1 [$];

  int pending_idx  = -1;
  int consumed_idx = -1;

  function automatic void chk(string name, int k, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, k, act, expv, $time);
    end
  endfunction

  // Reference model over the whole stream: hunt for a sync byte, require
  // the following sync bytes a packet apart, then forward packets while
  // counting consecutive missing syncs at packet starts.
  task automatic build_model(input int k, input int lc, input int uc);
    int n;
    int i;
    int lost;
    int pkt;
    int start;
    int p;
    int base;
    int miss;
    bit ok;
    n = stream.size();
    i = 0; lost = 0; pkt = 0;
    for (int j = 0; j < n; j++) begin
      exp_emit[k][j] = 1'b0; exp_sync[k][j] = 1'b0; exp_lock[k][j] = 1'b0;
    end
    while (i < n) begin
      if (stream[i] != SYNC) begin
        exp_lost[k][i] = lost; exp_pkt[k][i] = pkt;
        i++;
        continue;
      end
      start = i; ok = 1'b1;
      for (int g = 1; g < lc; g++) begin
        p = start + PKT * g;
        if (p >= n) begin ok = 1'b0; i = n; break; end
        if (stream[p] != SYNC) begin ok = 1'b0; i = p + 1; break; end
      end
      base = ok ? start + PKT * (lc - 1) : i;
      for (int j = start; j < base; j++) begin
        exp_lost[k][j] = lost; exp_pkt[k][j] = pkt;
      end
      if (!ok) continue;
      i = base; miss = 0;
      while (i < n) begin
        exp_pkt[k][i] = pkt;
        if ((i - base) % PKT == 0) begin
          if (stream[i] == SYNC) miss = 0;
          else miss++;
          if (miss >= uc) begin
            lost++;
            exp_lost[k][i] = lost;
            i++;
            break;
          end
          exp_sync[k][i] = 1'b1;
          pkt++;
        end
        exp_emit[k][i] = 1'b1;
        exp_lock[k][i] = 1'b1;
        exp_lost[k][i] = lost;
        i++;
      end
    end
    tot_pkt[k]  = pkt;
    tot_lost[k] = lost;
  endtask

  task automatic step();
    @(posedge clk);
    consumed_idx = pending_idx;
    #1;
  endtask

  task automatic do_reset();
    repeat (2) begin
      step();
      rst_n = 1'b0; in_valid = 1'b0; pending_idx = -1;
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_zero(string tag);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_valid"}, k, o_valid[k], 0);
      chk({tag, "_sync"},  k, o_sync[k],  0);
      chk({tag, "_locked"}, k, o_lock[k], 0);
      chk({tag, "_data"},  k, o_data[k],  0);
      chk({tag, "_pkt"},   k, o_pkt[k],   0);
      chk({tag, "_lost"},  k, o_lost[k],  0);
    end
  endtask

  // gap_mode: 0 = continuous, 1 = idle every 3rd cycle, 2 = random idles
  task automatic drive_stream(input int gap_mode, input string tag);
    int i;
    int cyc;
    bit gap;
    exp_t e;
    build_model(0, 3, 3);
    build_model(1, 2, 1);
    i = 0; cyc = 0;
    while (i < stream.size()) begin
      step();
      gap = (gap_mode == 1) ? (cyc % 3 == 2)
          : (gap_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (gap) begin
        in_valid = 1'b0; in_data = 8'($urandom_range(0, 255)); pending_idx = -1;
      end else begin
        in_valid = 1'b1; in_data = stream[i]; pending_idx = i;
        for (int k = 0; k < 2; k++) begin
          if (exp_emit[k][i]) begin
            e.idx = i; e.data = stream[i]; e.sync = exp_sync[k][i];
            if (k == 0) sb0.push_back(e); else sb1.push_back(e);
          end
        end
        i++;
      end
      cyc++;
    end
    repeat (3) begin
      step();
      in_valid = 1'b0; pending_idx = -1;
    end
    @(negedge clk);
    chk({tag, "_sb_empty"}, 0, sb0.size(), 0);
    chk({tag, "_sb_empty"}, 1, sb1.size(), 0);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_pkt_total"},  k, o_pkt[k],  tot_pkt[k]);
      chk({tag, "_lost_total"}, k, o_lost[k], tot_lost[k]);
    end
    $display("test %s: inst0 packets=%0d lost=%0d, inst1 packets=%0d lost=%0d",
             tag, o_pkt[0], o_lost[0], o_pkt[1], o_lost[1]);
  endtask

  function automatic logic [7:0] clean_payload(int j);
    int v;
    v = j - 1;
    if (v >= 'h47) v++;
    return 8'(v);
  endfunction

  task automatic add_packet(input logic [7:0] sync_val, input bit rnd);
    stream.push_back(sync_val);
    for (int j = 1; j < PKT; j++)
      stream.push_back(rnd ? 8'($urandom_range(0, 255)) : clean_payload(j));
  endtask

  // Monitor: pops expectations whenever a DUT presents a byte.
  always @(negedge clk) begin : monitor
    int ci;
    exp_t e;
    ci = consumed_idx;
    for (int k = 0; k < 2; k++) begin
      if (o_sync[k] && !o_valid[k]) chk("sync_without_valid", k, 1, 0);
      if (ci >= 0) begin
        chk("valid", k, o_valid[k], exp_emit[k][ci]);
        chk("locked", k, o_lock[k], exp_lock[k][ci]);
        chk("lost_count", k, o_lost[k], exp_lost[k][ci]);
        chk("packet_count", k, o_pkt[k], exp_pkt[k][ci]);
      end else if (rst_n) begin
        chk("valid_idle", k, o_valid[k], 0);
      end
      if (o_valid[k]) begin
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
          chk("unexpected_output", k, 1, 0);
        end else begin
          if (k == 0) e = sb0.pop_front(); else e = sb1.pop_front();
          chk("out_index", k, ci, e.idx);
          chk("out_data", k, o_data[k], e.data);
          chk("out_sync", k, o_sync[k], e.sync);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_zero("reset");

    // Clean stream
    stream.delete();
    for (int p = 0; p < 5; p++) add_packet(SYNC, 1'b0);
    do_reset();
    drive_stream(0, "clean");
    chk("clean_pkts_fixed", 0, o_pkt[0], 3);
    chk("clean_lost_fixed", 0, o_lost[0], 0);

    // Gapped valid, same stream
    do_reset();
    drive_stream(1, "gapped");
    chk("gapped_pkts_fixed", 0, o_pkt[0], 3);

    // False sync ahead of the true alignment
    stream.delete();
    for (int j = 0; j < 60; j++) stream.push_back((j == 10) ? SYNC : 8'(8'h10 + j));
    for (int p = 0; p < 7; p++) add_packet(SYNC, 1'b0);
    do_reset();
    drive_stream(0, "false_sync");

    // Flywheel: two corruptions recover, three in a row lose lock
    stream.delete();
    for (int p = 0; p < 15; p++)
      add_packet((p == 4 || p == 5 || p == 8 || p == 9 || p == 10) ? 8'h00 : SYNC, 1'b0);
    do_reset();
    drive_stream(0, "flywheel");
    chk("flywheel_lost_fixed", 0, o_lost[0], 1);
    chk("flywheel_lost_fixed", 1, o_lost[1], 2);

    // Reset in the middle of a locked packet
    stream.delete();
    for (int p = 0; p < 3; p++) add_packet(SYNC, 1'b0);
    for (int j = 0; j < 101; j++) stream.push_back((j == 0) ? SYNC : clean_payload(j));
    do_reset();
    drive_stream(0, "pre_reset");
    step();
    rst_n = 1'b0; in_valid = 1'b1; in_data = SYNC; pending_idx = -1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check_zero("mid_reset");
    stream.delete();
    for (int p = 0; p < 4; p++) add_packet(SYNC, 1'b0);
    drive_stream(0, "post_reset");

    // Randomized streams: random lead-in, random payload, occasional
    // corrupted syncs and random idle cycles
    for (int r = 0; r < 3; r++) begin
      stream.delete();
      for (int j = 0, n = $urandom_range(0, 200); j < n; j++)
        stream.push_back(($urandom_range(0, 15) == 0) ? SYNC : 8'($urandom_range(0, 255)));
      for (int p = 0; p < 8; p++)
        add_packet(($urandom_range(0, 4) == 0) ? 8'h00 : SYNC, 1'b1);
      do_reset();
      drive_stream(2, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
